rptr_empty_ctrl: RTL and testbench

Read-side pointer and status controller for the asynchronous FIFO. It is the counterpart of the write-pointer/full-flag logic on the write side. It keeps the binary and Gray read pointers in the read clock domain and compares them against the write pointer already synchronised into that domain. From that comparison it produces the read address, a registered empty flag, an almost-empty flag, the read-side fill level and a sticky underflow error.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/gray2bin_conv.sv | 14 +
 rtl/rptr_empty_ctrl.sv | 68 ++++++
 tb/tb_rptr_empty_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry, pointer type and Gray/binary helpers.
// Both the read-side and write-side controllers import this package.
package fifo_pkg;

   localparam int FIFO_ADDR_SIZE = 4;
   localparam int FIFO_AE_THRESH = 2;

   typedef logic [FIFO_ADDR_SIZE:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t bin);
      return (bin >> 1) ^ bin;
   endfunction

   function automatic ptr_t gray2bin(input ptr_t gray);
      ptr_t bin;
      bin[FIFO_ADDR_SIZE] = gray[FIFO_ADDR_SIZE];
      for (int i = FIFO_ADDR_SIZE - 1; i >= 0; i--)
         bin[i] = bin[i+1] ^ gray[i];
      return bin;
   endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin_conv #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^gray[WIDTH-1:i];
   end

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer and status controller of the async FIFO: binary/Gray read
// pointers plus registered empty, almost-empty, fill level and sticky underflow.
module rptr_empty_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_SIZE = FIFO_ADDR_SIZE,
   parameter int AE_THRESH = FIFO_AE_THRESH
) (
   input  logic                 rclk,
   input  logic                 rrst,
   input  logic                 rinc,
   input  logic [ADDR_SIZE:0]   rq2_wptr,
   output logic [ADDR_SIZE-1:0] raddr,
   output logic [ADDR_SIZE:0]   rptr,
   output logic                 rempty,
   output logic                 ralmost_empty,
   output logic [ADDR_SIZE:0]   rlevel,
   output logic                 runderflow
);

   localparam logic [ADDR_SIZE:0] AE_LIMIT = (ADDR_SIZE+1)'(AE_THRESH);

   logic [ADDR_SIZE:0] rbin;
   logic [ADDR_SIZE:0] rbin_next;
   logic [ADDR_SIZE:0] rgray_next;
   logic [ADDR_SIZE:0] wbin_s;
   logic [ADDR_SIZE:0] level_next;
   logic               pop;

   gray2bin_conv #(
      .WIDTH (ADDR_SIZE + 1)
   ) u_wptr_conv (
      .gray (rq2_wptr),
      .bin  (wbin_s)
   );

   assign pop = rinc & ~rempty;

   // NOTE: every signal written here gets a value on every pass, so no latch is inferred.
   always_comb begin
      rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, pop};
      rgray_next = (rbin_next >> 1) ^ rbin_next;
      // Full-width subtraction keeps the wrap bit, so a full FIFO reads as 2**ADDR_SIZE, not 0.
      level_next = wbin_s - rbin_next;
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rbin          <= '0;
         rptr          <= '0;
         rempty        <= 1'b1;
         ralmost_empty <= 1'b1;
         rlevel        <= '0;
         runderflow    <= 1'b0;
      end else begin
         rbin          <= rbin_next;
         rptr          <= rgray_next;
         rempty        <= (rgray_next == rq2_wptr);
         ralmost_empty <= (level_next <= AE_LIMIT);
         rlevel        <= level_next;
         runderflow    <= runderflow | (rinc & rempty);
      end
   end

   assign raddr = rbin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Directed bench for rptr_empty_ctrl: a vector table for the main pop/fill
// sequence plus hand-written reset, full-view and wrap-around sequences.
module tb_rptr_empty_ctrl;
   import fifo_pkg::*;

   logic       rclk = 1'b0;
   logic       rrst;
   logic       rinc;
   ptr_t       rq2_wptr;
   logic [3:0] raddr;
   ptr_t       rptr;
   logic       rempty;
   logic       ralmost_empty;
   ptr_t       rlevel;
   logic       runderflow;

   int n_vec = 0;
   int n_err = 0;

   rptr_empty_ctrl #(
      .ADDR_SIZE (4),
      .AE_THRESH (2)
   ) dut (
      .rclk          (rclk),
      .rrst          (rrst),
      .rinc          (rinc),
      .rq2_wptr      (rq2_wptr),
      .raddr         (raddr),
      .rptr          (rptr),
      .rempty        (rempty),
      .ralmost_empty (ralmost_empty),
      .rlevel        (rlevel),
      .runderflow    (runderflow)
   );

   always #5 rclk = ~rclk;

   typedef struct {
      logic       rinc;
      ptr_t       wptr;
      ptr_t       rptr;
      logic [3:0] raddr;
      logic       rempty;
      logic       ae;
      ptr_t       rlevel;
      logic       uf;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input ptr_t e_rptr, input logic [3:0] e_raddr,
                            input logic e_empty, input logic e_ae, input ptr_t e_level,
                            input logic e_uf);
      check({tag, ".rptr"},   rptr,          e_rptr);
      check({tag, ".raddr"},  raddr,         e_raddr);
      check({tag, ".rempty"}, rempty,        e_empty);
      check({tag, ".ae"},     ralmost_empty, e_ae);
      check({tag, ".rlevel"}, rlevel,        e_level);
      check({tag, ".uf"},     runderflow,    e_uf);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      ptr_t prev;
      ptr_t wbin;
      logic wrap_seen;

      //            rinc wptr            rptr    raddr e  ae level   uf
      vecs[0]  = '{1'b1, bin2gray(5'd0), 5'd0, 4'd0, 1, 1, 5'd0, 1}; // empty read
      vecs[1]  = '{1'b1, bin2gray(5'd0), 5'd0, 4'd0, 1, 1, 5'd0, 1};
      vecs[2]  = '{1'b1, bin2gray(5'd0), 5'd0, 4'd0, 1, 1, 5'd0, 1};
      vecs[3]  = '{1'b0, bin2gray(5'd5), 5'd0, 4'd0, 0, 0, 5'd5, 1}; // five words arrive
      vecs[4]  = '{1'b1, bin2gray(5'd5), 5'd1, 4'd1, 0, 0, 5'd4, 1};
      vecs[5]  = '{1'b1, bin2gray(5'd5), 5'd3, 4'd2, 0, 0, 5'd3, 1};
      vecs[6]  = '{1'b1, bin2gray(5'd5), 5'd2, 4'd3, 0, 1, 5'd2, 1};
      vecs[7]  = '{1'b1, bin2gray(5'd5), 5'd6, 4'd4, 0, 1, 5'd1, 1};
      vecs[8]  = '{1'b1, bin2gray(5'd5), 5'd7, 4'd5, 1, 1, 5'd0, 1}; // last word
      vecs[9]  = '{1'b1, bin2gray(5'd5), 5'd7, 4'd5, 1, 1, 5'd0, 1}; // blocked pop
      vecs[10] = '{1'b0, bin2gray(5'd6), 5'd7, 4'd5, 0, 1, 5'd1, 1};
      vecs[11] = '{1'b1, bin2gray(5'd7), 5'd5, 4'd6, 0, 1, 5'd1, 1}; // pop + write together

      rrst = 1'b1;
      rinc = 1'b0;
      rq2_wptr = '0;
      #1;
      check_all("reset0", 5'd0, 4'd0, 1'b1, 1'b1, 5'd0, 1'b0);
      @(negedge rclk);
      @(negedge rclk);
      rrst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         rinc = vecs[i].rinc;
         rq2_wptr = vecs[i].wptr;
         @(posedge rclk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].rptr, vecs[i].raddr, vecs[i].rempty,
                   vecs[i].ae, vecs[i].rlevel, vecs[i].uf);
         @(negedge rclk);
      end

      // Pop the last word to reach rbin=7, then reset asynchronously mid-cycle.
      rinc = 1'b1;
      rq2_wptr = bin2gray(5'd7);
      @(posedge rclk);
      #1;
      check("pre_rst.raddr", raddr, 4'd7);
      check("pre_rst.rempty", rempty, 1'b1);
      #2;
      rrst = 1'b1;
      #1;
      check_all("async_rst", 5'd0, 4'd0, 1'b1, 1'b1, 5'd0, 1'b0);
      @(posedge rclk);
      #1;
      check("rst_held.rempty", rempty, 1'b1);
      check("rst_held.rptr", rptr, 5'd0);

      // Full view: write pointer a whole lap ahead of rbin=0.
      @(negedge rclk);
      rrst = 1'b0;
      rinc = 1'b0;
      rq2_wptr = bin2gray(5'd16);
      @(posedge rclk);
      #1;
      check_all("full", 5'd0, 4'd0, 1'b0, 1'b0, 5'd16, 1'b0);
      @(negedge rclk);
      rinc = 1'b1;
      @(posedge rclk);
      #1;
      check_all("full_pop", 5'd1, 4'd1, 1'b0, 1'b0, 5'd15, 1'b0);

      // Continuous write/read stream through the pointer wrap.
      @(negedge rclk);
      rrst = 1'b1;
      rinc = 1'b0;
      rq2_wptr = '0;
      @(negedge rclk);
      rrst = 1'b0;
      wbin = '0;
      prev = '0;
      wrap_seen = 1'b0;
      for (int i = 1; i <= 45; i++) begin
         wbin = wbin + 5'd1;
         rq2_wptr = bin2gray(wbin);
         rinc = 1'b1;
         @(posedge rclk);
         #1;
         check($sformatf("wrap%0d.rptr", i), rptr, bin2gray(5'(i - 1)));
         check($sformatf("wrap%0d.rlevel", i), rlevel, 5'd1);
         check($sformatf("wrap%0d.rempty", i), rempty, 1'b0);
         if (i >= 2)
            check($sformatf("wrap%0d.gray_step", i), $countones(prev ^ rptr), 1);
         if (prev == 5'd16 && rptr == 5'd0)
            wrap_seen = 1'b1;
         prev = rptr;
         @(negedge rclk);
      end
      check("wrap.seen_31_to_0", wrap_seen, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
